// File: rtl/forward_ctrl_pkg.sv
// Shared types and constants for the decode-stage forwarding scheduler.
// Stage codes double as forward-select values (FWD_E=1 .. FWD_M5=6).
package forward_ctrl_pkg;

    localparam int FWD_NSTAGE = 6;
    localparam int FWD_RW     = 6;
    localparam int FWD_NSRC   = 6;

    typedef enum logic [2:0] {
        FWD_REG = 3'd0,
        FWD_E   = 3'd1,
        FWD_M   = 3'd2,
        FWD_M2  = 3'd3,
        FWD_M3  = 3'd4,
        FWD_M4  = 3'd5,
        FWD_M5  = 3'd6
    } fwd_sel_t;

    localparam logic [2:0] LAT_ALU  = 3'd1;
    localparam logic [2:0] LAT_LOAD = 3'd3;
    localparam logic [2:0] LAT_FPU  = 3'd5;

    typedef struct packed {
        logic              valid;
        logic [FWD_RW-1:0] rd;
        logic              regwrite;
        logic [2:0]        lat;
    } fwd_slot_t;

    // Clamp a producer latency into the tracked window 1..FWD_NSTAGE.
    function automatic logic [2:0] norm_lat(input logic [2:0] lat);
        if (lat == 3'd0)
            return 3'd1;
        if (lat > 3'(FWD_NSTAGE))
            return 3'(FWD_NSTAGE);
        return lat;
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_pick.sv
// Matches one source operand against the in-flight slots and returns the
// forward select of the youngest writer, or flags it unready if not yet produced.
module fwd_pick
    import forward_ctrl_pkg::*;
#(
    parameter int NSTAGE = FWD_NSTAGE
) (
    input  logic [FWD_RW-1:0]     i_src,
    input  fwd_slot_t [NSTAGE:1]  i_slots,
    output fwd_sel_t              o_sel,
    output logic                  o_unready
);

    always_comb begin
        o_sel     = FWD_REG;
        o_unready = 1'b0;
        // Walk oldest to youngest so the youngest matching writer overrides.
        for (int k = NSTAGE; k >= 1; k--) begin
            if (i_slots[k].valid && i_slots[k].regwrite &&
                (i_slots[k].rd == i_src) && (i_src != '0)) begin
                if (3'(k) >= i_slots[k].lat) begin
                    o_sel     = fwd_sel_t'(3'(k));
                    o_unready = 1'b0;
                end else begin
                    o_sel     = FWD_REG;
                    o_unready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Decode-stage hazard/forwarding scheduler: slot shift register, per-source picks,
// stall/hazard reduction. Define FORWARD_CTRL_STATS_EN to add saturating stat counters.
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int NSTAGE = FWD_NSTAGE,
    parameter int RW     = FWD_RW
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          dec_valid,
    input  logic [RW-1:0]                 dec_rd,
    input  logic                          dec_regwrite,
    input  logic [2:0]                    dec_lat,
    input  logic [FWD_NSRC-1:0][RW-1:0]   src_addr,
    input  logic [FWD_NSRC-1:0]           src_used,
    input  logic                          exe_hold,
    input  logic                          flush,
    output logic [FWD_NSRC-1:0][2:0]      forward,
    output logic                          stall,
    output logic                          hazard
`ifdef FORWARD_CTRL_STATS_EN
    ,
    output logic [31:0]                   stat_stall,
    output logic [31:0]                   stat_hazard,
    output logic [31:0]                   stat_fwd
`endif
);

    fwd_slot_t [NSTAGE:1]   r_slot;
    fwd_slot_t              w_ins;
    fwd_sel_t               w_sel [FWD_NSRC];
    logic [FWD_NSRC-1:0]    w_unready;

    generate
        for (genvar gi = 0; gi < FWD_NSRC; gi++) begin : g_pick
            fwd_pick #(.NSTAGE(NSTAGE)) u_pick (
                .i_src     (src_addr[gi]),
                .i_slots   (r_slot),
                .o_sel     (w_sel[gi]),
                .o_unready (w_unready[gi])
            );
            assign forward[gi] = w_sel[gi];
        end
    endgenerate

    assign hazard = dec_valid & (|(w_unready & src_used));
    assign stall  = hazard | exe_hold;

    // A stalled or flushed decode instruction enters E as an all-zero bubble.
    always_comb begin
        w_ins = '0;
        if (dec_valid && !hazard && !flush) begin
            w_ins.valid    = 1'b1;
            w_ins.rd       = dec_rd;
            w_ins.regwrite = dec_regwrite;
            w_ins.lat      = norm_lat(dec_lat);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slot <= '0;
        end else if (!exe_hold) begin
            for (int k = NSTAGE; k >= 2; k--)
                r_slot[k] <= r_slot[k-1];
            r_slot[1] <= w_ins;
        end
    end

    a_no_flush_on_hold : assert property (@(posedge clk) disable iff (!rstn)
        !(flush && exe_hold));

`ifdef FORWARD_CTRL_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_hazard;
    logic [31:0] r_stat_fwd;
    logic        w_any_fwd;

    always_comb begin
        w_any_fwd = 1'b0;
        for (int i = 0; i < FWD_NSRC; i++)
            if (src_used[i] && (forward[i] != 3'd0))
                w_any_fwd = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_stall  <= '0;
            r_stat_hazard <= '0;
            r_stat_fwd    <= '0;
        end else begin
            if (stall && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 32'd1;
            if (hazard && (r_stat_hazard != '1))
                r_stat_hazard <= r_stat_hazard + 32'd1;
            if (w_any_fwd && (r_stat_fwd != '1))
                r_stat_fwd <= r_stat_fwd + 32'd1;
        end
    end

    assign stat_stall  = r_stat_stall;
    assign stat_hazard = r_stat_hazard;
    assign stat_fwd    = r_stat_fwd;
`endif

endmodule
